hx8352_seq_engine: RTL and testbench

- Parametrised successor of the fixed LCD init sequencer: runs any command/data/delay sequence held in an external sequence ROM, starting at a caller-supplied base address.
- The same engine serves power-on init, sleep-in/out and window-setup sequences.
- Sits between the top-level LCD controller and the shared bus writer and delay timer blocks.
- Entry format is {tag[1:0], payload[DW-1:0]}; tag values: 00 = CMD, 01 = DATA, 10 = DELAY, 11 = END.

---
 rtl/hx8352_seq_engine.sv | 138 +++++++++++++
 tb/tb_hx8352_seq_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hx8352_seq_engine.sv
// hx8352_seq_engine: ROM-driven LCD command/data/delay sequencer for the HX8352 bus writer.
// Entry format {tag[1:0], payload[DW-1:0]}: 00 CMD, 01 DATA, 10 DELAY, 11 END.
// Define HX8352_SEQ_TIMEOUT_EN to add a BUS_WAIT watchdog that ends a stuck sequence with status 11.
module hx8352_seq_engine #(
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int CS_SETUP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] seq_base,
    input  logic          abort,
    output logic [AW-1:0] rom_addr,
    input  logic [DW+1:0] rom_data,
    output logic          bus_step,
    output logic          command_or_data,
    output logic [DW-1:0] data_to_write,
    input  logic          bus_done,
    output logic          delay_step,
    output logic [DW-1:0] delay_value,
    input  logic          delay_done,
    output logic          lcd_cs,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status
);
    localparam int CW = CS_SETUP > 1 ? $clog2(CS_SETUP) : 1;
    localparam logic [CW-1:0] CS_LAST = CW'(CS_SETUP - 1);
    localparam logic [1:0] T_DELAY = 2'b10;
    localparam logic [1:0] ST_OK = 2'b00, ST_ABORT = 2'b01, ST_OVERRUN = 2'b10, ST_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_SETUP, S_FETCH, S_FETCH_WAIT, S_DECODE,
        S_BUS_ISSUE, S_BUS_WAIT, S_DELAY_ISSUE, S_DELAY_WAIT, S_FINISH
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cs_cnt;
    logic [1:0]      fin;
    logic            adv;
    logic [1:0]      tag;
    logic [DW-1:0]   payload;
    logic            last;

    assign tag      = rom_data[DW+1:DW];
    assign payload  = rom_data[DW-1:0];
    assign last     = &rom_addr;
    assign bus_step   = state == S_BUS_ISSUE;
    assign delay_step = state == S_DELAY_ISSUE;
    assign done       = state == S_FINISH;
    assign busy       = state != S_IDLE && state != S_FINISH;
    assign lcd_cs     = !busy;

`ifdef HX8352_SEQ_TIMEOUT_EN
    // Watchdog reads 1 in the first BUS_WAIT cycle, so hitting WD_LAST puts FINISH 1023 cycles after bus_step.
    localparam logic [15:0] WD_LAST = 16'd1022;
    logic [15:0] wd;
    logic        wd_expired;
    assign wd_expired = wd == WD_LAST;

    // Cycle counter for the current bus transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd <= '0;
        else wd <= state == S_BUS_ISSUE ? 16'd1 : state == S_BUS_WAIT ? wd + 16'd1 : wd;
    end
`else
    logic wd_expired;
    assign wd_expired = 1'b0;
`endif

    // Next-state, finishing status and address-advance decision
    always_comb begin
        state_nxt = state;
        fin = ST_OK;
        adv = 1'b0;
        case (state)
            S_IDLE:        state_nxt = start ? S_CS_SETUP : S_IDLE;
            S_CS_SETUP:    state_nxt = cs_cnt == CS_LAST ? S_FETCH : S_CS_SETUP;
            S_FETCH:       state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (!tag[1]) state_nxt = S_BUS_ISSUE;
                else if (tag == T_DELAY) begin
                    state_nxt = payload != '0 ? S_DELAY_ISSUE : S_DECODE;
                    adv = payload == '0;
                end else state_nxt = S_FINISH;
            end
            S_BUS_ISSUE:   state_nxt = S_BUS_WAIT;
            S_BUS_WAIT: begin
                adv = bus_done;
                if (!bus_done && wd_expired) begin
                    state_nxt = S_FINISH;
                    fin = ST_TIMEOUT;
                end
            end
            S_DELAY_ISSUE: state_nxt = S_DELAY_WAIT;
            S_DELAY_WAIT:  adv = delay_done;
            default:       state_nxt = S_IDLE;
        endcase
        if (adv) begin
            state_nxt = last ? S_FINISH : S_FETCH;
            fin = last ? ST_OVERRUN : ST_OK;
        end
        if (abort && state != S_IDLE && state != S_FINISH) begin
            state_nxt = S_FINISH;
            fin = ST_ABORT;
            adv = 1'b0;
        end
    end

    // State, address, payload and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            cs_cnt          <= '0;
            rom_addr        <= '0;
            command_or_data <= 1'b0;
            data_to_write   <= '0;
            delay_value     <= '0;
            status          <= ST_OK;
        end else begin
            state  <= state_nxt;
            cs_cnt <= state == S_CS_SETUP ? cs_cnt + 1'b1 : '0;
            if (state == S_IDLE && start) begin
                rom_addr <= seq_base;
                status   <= ST_OK;
            end
            if (adv && !last) rom_addr <= rom_addr + 1'b1;
            if (state == S_DECODE && !tag[1]) begin
                command_or_data <= tag[0];
                data_to_write   <= payload;
            end
            if (state == S_DECODE && tag == T_DELAY) delay_value <= payload;
            if (state_nxt == S_FINISH && state != S_FINISH) status <= fin;
        end
    end
endmodule

// File: tb/tb_hx8352_seq_engine.sv
// tb_hx8352_seq_engine: directed scoreboard bench for the HX8352 sequence engine.
module tb_hx8352_seq_engine;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic        bus_done = 1'b0, delay_done = 1'b0;
    logic [7:0]  seq_base = '0, rom_addr;
    logic [17:0] rom_data;
    logic        bus_step, command_or_data, delay_step, lcd_cs, busy, done;
    logic [15:0] data_to_write, delay_value;
    logic [1:0]  status;
    logic [17:0] rom [256];

    typedef struct { logic [1:0] kind; logic [15:0] val; } exp_t;
    exp_t sb[$];
    int total = 0, passed = 0, fails = 0;
    int bc, dc, cs_bad, tail_act, first_bus, done_cyc;

    hx8352_seq_engine #(.DW(16), .AW(8), .CS_SETUP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .seq_base(seq_base), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .bus_step(bus_step), .command_or_data(command_or_data), .data_to_write(data_to_write), .bus_done(bus_done),
        .delay_step(delay_step), .delay_value(delay_value), .delay_done(delay_done),
        .lcd_cs(lcd_cs), .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] v);
        sb.push_back('{k, v});
    endtask

    task automatic service(input int lat, input int dlat);
        exp_t e;
        bus_done = 1'b0;
        delay_done = 1'b0;
        if (busy && lcd_cs !== 1'b0) cs_bad++;
        if (bc > 0) begin bc--; bus_done = (bc == 0); end
        if (dc > 0) begin dc--; delay_done = (dc == 0); end
        if (bus_step) begin
            chk("bus_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("bus_kind", 32'(command_or_data), 32'(e.kind));
                chk("bus_data", 32'(data_to_write), 32'(e.val));
            end
            bc = lat;
        end
        if (delay_step) begin
            chk("delay_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("delay_kind", 32'd2, 32'(e.kind));
                chk("delay_value", 32'(delay_value), 32'(e.val));
            end
            dc = dlat;
        end
    endtask

    task automatic run(input logic [7:0] base, input int lat, input int dlat,
                       input int ab_from, input int ab_to, input int restart_at, input int max_cyc);
        bc = 0; dc = 0; cs_bad = 0; tail_act = 0; first_bus = -1; done_cyc = -1;
        @(negedge clk);
        seq_base = base;
        start = 1'b1;
        abort = (ab_from == 0);
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (start) seq_base = 8'hFE;
            abort = (c >= ab_from && c <= ab_to);
            service(lat, dlat);
            if (bus_step && first_bus < 0) first_bus = c;
            if (done) begin done_cyc = c; break; end
        end
        start = 1'b0;
        abort = 1'b0;
        if (done_cyc >= 0) repeat (8) begin
            @(negedge clk);
            service(lat, dlat);
            if (busy || done || !lcd_cs || bus_step || delay_step) tail_act++;
        end
    endtask

    task automatic reset_mid_run();
        @(posedge clk);
        #2 rst = 1'b0;
        bus_done = 1'b0;
        delay_done = 1'b0;
        #1;
        chk("arst_lcd_cs", 32'(lcd_cs), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_data", 32'(data_to_write), 32'd0);
        chk("arst_bus_step", 32'(bus_step), 32'd0);
        @(negedge clk) rst = 1'b1;
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {2'b11, 16'h0000};
        rom[8'h10] = {2'b00, 16'h0022};
        rom[8'h11] = {2'b01, 16'h1234};
        rom[8'h12] = {2'b01, 16'h5678};
        rom[8'h20] = {2'b00, 16'h0001};
        rom[8'h21] = {2'b10, 16'h0064};
        rom[8'h22] = {2'b10, 16'h0000};
        rom[8'hFE] = {2'b00, 16'h00AA};
        rom[8'hFF] = {2'b00, 16'h00BB};
        rom[8'h00] = {2'b00, 16'h0EEE};

        repeat (3) @(negedge clk);
        chk("rst_lcd_cs", 32'(lcd_cs), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_steps", 32'({bus_step, delay_step, command_or_data}), 32'd0);
        chk("rst_payloads", 32'({data_to_write, delay_value}), 32'd0);
        rst = 1'b1;

        push(2'd0, 16'h0022); push(2'd1, 16'h1234); push(2'd1, 16'h5678);
        run(8'h10, 3, 0, -1, -1, -1, 200);
        chk("basic_first_bus", 32'(first_bus), 32'd6);
        chk("basic_done_cyc", 32'(done_cyc), 32'd27);
        chk("basic_status", 32'(status), 32'd0);
        chk("basic_sb_empty", 32'(sb.size()), 32'd0);
        chk("basic_cs_low", 32'(cs_bad), 32'd0);
        chk("basic_tail", 32'(tail_act), 32'd0);

        push(2'd0, 16'h0001); push(2'd2, 16'h0064);
        run(8'h20, 3, 5, -1, -1, -1, 200);
        chk("delay_done_cyc", 32'(done_cyc), 32'd25);
        chk("delay_status", 32'(status), 32'd0);
        chk("delay_sb_empty", 32'(sb.size()), 32'd0);
        chk("delay_tail", 32'(tail_act), 32'd0);

        push(2'd0, 16'h00AA); push(2'd0, 16'h00BB);
        run(8'hFE, 3, 0, -1, -1, -1, 200);
        chk("ovr_done_cyc", 32'(done_cyc), 32'd17);
        chk("ovr_status", 32'(status), 32'd2);
        chk("ovr_no_wrap", 32'(rom_addr), 32'hFF);
        chk("ovr_sb_empty", 32'(sb.size()), 32'd0);
        chk("ovr_tail", 32'(tail_act), 32'd0);

        push(2'd0, 16'h0022);
        run(8'h10, 6, 0, 8, 8, -1, 200);
        chk("abort_done_cyc", 32'(done_cyc), 32'd9);
        chk("abort_status", 32'(status), 32'd1);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        chk("abort_late_done_ignored", 32'(tail_act), 32'd0);

        push(2'd0, 16'h0022); push(2'd1, 16'h1234); push(2'd1, 16'h5678);
        run(8'h10, 3, 0, -1, -1, -1, 200);
        chk("rerun_status", 32'(status), 32'd0);
        chk("rerun_sb_empty", 32'(sb.size()), 32'd0);

        push(2'd0, 16'h0022); push(2'd1, 16'h1234); push(2'd1, 16'h5678);
        run(8'h10, 3, 0, -1, -1, 4, 200);
        chk("restart_done_cyc", 32'(done_cyc), 32'd27);
        chk("restart_status", 32'(status), 32'd0);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        run(8'h10, 3, 0, 0, 1, -1, 50);
        chk("startabort_done_cyc", 32'(done_cyc), 32'd2);
        chk("startabort_status", 32'(status), 32'd1);
        chk("startabort_no_bus", 32'(first_bus), 32'hFFFF_FFFF);

        push(2'd0, 16'h0022);
        run(8'h10, 3, 0, -1, -1, -1, 12);
        chk("midrst_running", 32'(busy), 32'd1);
        chk("midrst_not_done", 32'(done_cyc), 32'hFFFF_FFFF);
        reset_mid_run();

        push(2'd0, 16'h0022);
`ifdef HX8352_SEQ_TIMEOUT_EN
        run(8'h10, 0, 0, -1, -1, -1, 1100);
        chk("timeout_first_bus", 32'(first_bus), 32'd6);
        chk("timeout_done_cyc", 32'(done_cyc), 32'd1029);
        chk("timeout_status", 32'(status), 32'd3);
`else
        run(8'h10, 0, 0, -1, -1, -1, 5000);
        chk("notimeout_first_bus", 32'(first_bus), 32'd6);
        chk("notimeout_not_done", 32'(done_cyc), 32'hFFFF_FFFF);
        chk("notimeout_busy", 32'(busy), 32'd1);
        reset_mid_run();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
